// File: rtl/bf16_dot_acc.sv
// Streaming BF16 dot-product: registered BF16 multiply, then a BF16 accumulate, with one result per vector.
// Optional BF16_DOT_NAN_STICKY_EN: any NaN product/sum forces the result to 16'h7FC0 and raises out_nan.

// BF16 multiply, round-to-nearest-even; subnormal inputs/results flush to signed zero.
module bf16_mul (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              sgn, a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, grd, stk;
    logic [15:0]       prod;
    logic [6:0]        mant;
    logic [7:0]        mant_r;
    logic signed [9:0] exp_s;

    always_comb begin
        sgn    = a[15] ^ b[15];
        a_nan  = (&a[14:7]) & (|a[6:0]);
        b_nan  = (&b[14:7]) & (|b[6:0]);
        a_inf  = (&a[14:7]) & ~(|a[6:0]);
        b_inf  = (&b[14:7]) & ~(|b[6:0]);
        a_zero = ~(|a[14:7]);
        b_zero = ~(|b[14:7]);
        prod   = {8'b0, 1'b1, a[6:0]} * {8'b0, 1'b1, b[6:0]};
        exp_s  = $signed({2'b0, a[14:7]}) + $signed({2'b0, b[14:7]}) - 10'sd127;
        if (prod[15]) begin
            mant  = prod[14:8];
            grd   = prod[7];
            stk   = |prod[6:0];
            exp_s = exp_s + 10'sd1;
        end else begin
            mant  = prod[13:7];
            grd   = prod[6];
            stk   = |prod[5:0];
        end
        mant_r = {1'b0, mant} + {7'b0, grd & (stk | mant[0])};
        exp_s  = exp_s + (mant_r[7] ? 10'sd1 : 10'sd0);

        if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) y = 16'h7FC0;
        else if (a_inf | b_inf)                                  y = {sgn, 8'hFF, 7'h0};
        else if (a_zero | b_zero)                                y = {sgn, 15'h0};
        else if (exp_s >= 10'sd255)                              y = {sgn, 8'hFF, 7'h0};
        else if (exp_s <= 10'sd0)                                y = {sgn, 15'h0};
        else                                                     y = {sgn, exp_s[7:0], mant_r[6:0]};
    end
endmodule

// BF16 add, round-to-nearest-even with guard/round/sticky; subnormals flush to zero, exact cancel gives +0.
module bf16_add (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] y
);
    logic              a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sub, stk;
    logic [15:0]       big;
    logic [14:0]       sml;
    logic [7:0]        d, mant_r;
    logic [31:0]       sh;
    logic [10:0]       bm, sm, n;
    logic [11:0]       sum;
    logic [3:0]        lz;
    logic signed [9:0] e;

    function automatic logic [3:0] lzc11(input logic [10:0] v);
        lzc11 = 4'd11;
        for (int i = 0; i < 11; i++)
            if (v[i]) lzc11 = 4'(10 - i);
    endfunction

    always_comb begin
        a_nan  = (&a[14:7]) & (|a[6:0]);
        b_nan  = (&b[14:7]) & (|b[6:0]);
        a_inf  = (&a[14:7]) & ~(|a[6:0]);
        b_inf  = (&b[14:7]) & ~(|b[6:0]);
        a_zero = ~(|a[14:7]);
        b_zero = ~(|b[14:7]);
        sub    = a[15] ^ b[15];
        if (b[14:0] > a[14:0]) begin
            big = b;
            sml = a[14:0];
        end else begin
            big = a;
            sml = b[14:0];
        end
        // Align the smaller operand; everything shifted out folds into the sticky bit.
        d   = big[14:7] - sml[14:7];
        sh  = {1'b1, sml[6:0], 24'b0} >> d;
        stk = (d > 8'd31) ? 1'b1 : |sh[21:0];
        bm  = {1'b1, big[6:0], 3'b0};
        sm  = {sh[31:22], stk};
        sum = sub ? ({1'b0, bm} - {1'b0, sm}) : ({1'b0, bm} + {1'b0, sm});
        e   = $signed({2'b0, big[14:7]});
        lz  = 4'd0;
        if (!sub && sum[11]) begin
            n = {sum[11:2], sum[1] | sum[0]};
            e = e + 10'sd1;
        end else begin
            lz = lzc11(sum[10:0]);
            n  = sum[10:0] << lz;
            e  = e - $signed({6'b0, lz});
        end
        mant_r = {1'b0, n[9:3]} + {7'b0, n[2] & (n[1] | n[0] | n[3])};
        e      = e + (mant_r[7] ? 10'sd1 : 10'sd0);

        if (a_nan | b_nan | (a_inf & b_inf & sub)) y = 16'h7FC0;
        else if (a_inf)                            y = a;
        else if (b_inf)                            y = b;
        else if (a_zero & b_zero)                  y = {a[15] & b[15], 15'h0};
        else if (a_zero)                           y = b;
        else if (b_zero)                           y = a;
        else if (!n[10])                           y = 16'h0000;
        else if (e >= 10'sd255)                    y = {big[15], 8'hFF, 7'h0};
        else if (e <= 10'sd0)                      y = {big[15], 15'h0};
        else                                       y = {big[15], e[7:0], mant_r[6:0]};
    end
endmodule

module bf16_dot_acc #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [15:0]      in_a,
    input  logic [15:0]      in_b,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [15:0]      out_data,
    output logic [LEN_W-1:0] out_cnt,
    output logic             out_nan
);
    typedef enum logic {ACC, DONE} state_t;

    typedef struct packed {
        logic        last;
        logic [15:0] val;
    } prod_t;

    state_t            state;
    prod_t             p_reg;
    logic              p_valid, first, accept;
    logic [15:0]       acc, acc_next, mul_y, add_y;
    logic [LEN_W-1:0]  cnt, cnt_next;

    bf16_mul u_mul (.a(in_a), .b(in_b),      .y(mul_y));
    bf16_add u_add (.a(acc),  .b(p_reg.val), .y(add_y));

    // Holding off the next pair while the last product drains keeps vectors from merging.
    assign in_ready = rst_n & (state == ACC) & ~(p_valid & p_reg.last);
    assign accept   = in_valid & in_ready;
    assign acc_next = first ? p_reg.val : add_y;
    assign cnt_next = first ? LEN_W'(1) : ((&cnt) ? cnt : cnt + LEN_W'(1));

`ifdef BF16_DOT_NAN_STICKY_EN
    logic nan_sticky;

    function automatic logic is_nan(input logic [15:0] v);
        return (&v[14:7]) & (|v[6:0]);
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n)
            nan_sticky <= 1'b0;
        else if (state == DONE && out_ready)
            nan_sticky <= 1'b0;
        else if (state == ACC && p_valid)
            nan_sticky <= nan_sticky | is_nan(p_reg.val) | is_nan(acc_next);
    end

    assign out_data = nan_sticky ? 16'h7FC0 : acc;
    assign out_nan  = nan_sticky;
`else
    assign out_data = acc;
    assign out_nan  = 1'b0;
`endif

    assign out_valid = (state == DONE);
    assign out_cnt   = cnt;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ACC;
            p_valid <= 1'b0;
            p_reg   <= '0;
            first   <= 1'b1;
            acc     <= '0;
            cnt     <= '0;
        end else begin
            p_valid <= accept;
            if (accept) begin
                p_reg.val  <= mul_y;
                p_reg.last <= in_last;
            end
            case (state)
                ACC: if (p_valid) begin
                    acc   <= acc_next;
                    cnt   <= cnt_next;
                    first <= p_reg.last;
                    if (p_reg.last) state <= DONE;
                end
                DONE: if (out_ready) begin
                    state <= ACC;
                    cnt   <= '0;
                end
                default: state <= ACC;
            endcase
        end
    end
endmodule

// File: tb/tb_bf16_dot_acc.sv
// Scoreboard bench for bf16_dot_acc: expectations queued at stimulus time, checked on each result handshake.
module tb_bf16_dot_acc;
    logic        clk = 1'b0;
    logic        rst_n, in_valid, in_ready, in_last, out_valid, out_ready, out_nan;
    logic [15:0] in_a, in_b, out_data;
    logic [7:0]  out_cnt;

    typedef struct {
        logic [15:0] data;
        logic [7:0]  cnt;
        logic        nan;
        logic        any_nan;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_chk = 0;
    int   n_err = 0;
    int   w;

    bf16_dot_acc #(.LEN_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_last(in_last),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_cnt(out_cnt),
        .out_nan(out_nan)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic expect_res(input logic [15:0] data, input logic [7:0] cnt,
                              input logic nan, input logic any_nan);
        exp_t e;
        e.data = data; e.cnt = cnt; e.nan = nan; e.any_nan = any_nan;
        sb.push_back(e);
    endtask

    // Called just after a rising edge; returns just after the edge that took the pair.
    task automatic send(input logic [15:0] a, input logic [15:0] b, input logic last,
                        output int waited);
        in_a = a; in_b = b; in_last = last; in_valid = 1'b1;
        waited = 0;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            waited++;
            if (waited > 50) begin
                chk("accept_timeout", 32'(in_ready), 32'd1);
                break;
            end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("drain", sb.size(), 32'd0);
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
                chk("unexpected_result", 32'(out_valid), 32'd0);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.any_nan)
                    chk("res_is_nan", 32'((&out_data[14:7]) & (|out_data[6:0])), 32'd1);
                else
                    chk("res_data", 32'(out_data), 32'(mon_e.data));
                chk("res_cnt", 32'(out_cnt), 32'(mon_e.cnt));
                chk("res_nan", 32'(out_nan), 32'(mon_e.nan));
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog checks=%0d errors=%0d", n_chk, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data",  32'(out_data),  32'd0);
        chk("rst_out_cnt",   32'(out_cnt),   32'd0);
        chk("rst_out_nan",   32'(out_nan),   32'd0);
        chk("rst_in_ready",  32'(in_ready),  32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;

        // T1: single pair, two-edge latency
        expect_res(16'h4000, 8'd1, 1'b0, 1'b0);
        send(16'h3F80, 16'h4000, 1'b1, w);
        @(negedge clk);
        chk("t1_lat_edge1", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("t1_lat_edge2", 32'(out_valid), 32'd1);
        wait_drain();

        // T2 + T4: back-to-back vector, then hold the result under backpressure
        out_ready = 1'b0;
        expect_res(16'h4100, 8'd3, 1'b0, 1'b0);
        send(16'h4000, 16'h4000, 1'b0, w); chk("t2_stall0", w, 32'd0);
        send(16'h3F80, 16'h4040, 1'b0, w); chk("t2_stall1", w, 32'd0);
        send(16'h3F00, 16'h4000, 1'b1, w); chk("t2_stall2", w, 32'd0);
        for (int i = 0; i < 10 && !out_valid; i++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_hold_valid", 32'(out_valid), 32'd1);
            chk("t4_hold_data",  32'(out_data),  32'h4100);
            chk("t4_hold_cnt",   32'(out_cnt),   32'd3);
            chk("t4_hold_ready", 32'(in_ready),  32'd0);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        // T3 follows immediately: first pair must wait exactly one cycle for the handshake
        expect_res(16'hBF80, 8'd2, 1'b0, 1'b0);
        send(16'hBF80, 16'h4000, 1'b0, w); chk("t4_resume_wait", w, 32'd1);
        send(16'h3F80, 16'h3F80, 1'b1, w);
        wait_drain();

        // T5: reset mid-vector discards the partial sum
        send(16'h4000, 16'h4000, 1'b0, w);
        send(16'h3F80, 16'h3F80, 1'b0, w);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t5_no_out", 32'(out_valid), 32'd0);
            chk("t5_cnt_clr", 32'(out_cnt), 32'd0);
        end
        @(posedge clk); #1;
        expect_res(16'h4000, 8'd1, 1'b0, 1'b0);
        send(16'h3F80, 16'h4000, 1'b1, w);
        wait_drain();

        // Rounding, overflow to infinity, exact cancellation
        expect_res(16'h3F82, 8'd1, 1'b0, 1'b0);
        send(16'h3F81, 16'h3F81, 1'b1, w);
        expect_res(16'h7F80, 8'd1, 1'b0, 1'b0);
        send(16'h7F00, 16'h7F00, 1'b1, w);
        expect_res(16'h0000, 8'd2, 1'b0, 1'b0);
        send(16'h4000, 16'h3F80, 1'b0, w);
        send(16'hC000, 16'h3F80, 1'b1, w);
        wait_drain();

        // 300 ones: count saturates at 255, sum stalls at 256 (257 ties to even)
        expect_res(16'h4380, 8'd255, 1'b0, 1'b0);
        for (int i = 0; i < 300; i++) send(16'h3F80, 16'h3F80, (i == 299), w);
        wait_drain();

        // T6: NaN product, then a clean vector shows the flag cleared
`ifdef BF16_DOT_NAN_STICKY_EN
        expect_res(16'h7FC0, 8'd2, 1'b1, 1'b0);
`else
        expect_res(16'h7FC0, 8'd2, 1'b0, 1'b1);
`endif
        send(16'h7FC0, 16'h3F80, 1'b0, w);
        send(16'h3F80, 16'h3F80, 1'b1, w);
        expect_res(16'h4000, 8'd1, 1'b0, 1'b0);
        send(16'h3F80, 16'h4000, 1'b1, w);
        wait_drain();

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
